// File: rtl/i4004_defs.sv
// Shared definitions for the i4004 front-panel run controller: phase codes,
// controller FSM states and the 4004 program-counter width.
package i4004_defs;

  localparam int I4004_ADDR_W = 12;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic [2:0] {
    LOAD_IDLE = 3'd0,
    WR0       = 3'd1,
    WR1       = 3'd2,
    RUN_IDLE  = 3'd3,
    RD        = 3'd4,
    RD_CAP    = 3'd5
  } run_state_e;

  // The panel switches are wired MSB-last, so the word is mirrored end to end.
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/i4004_run_ctrl_sync_edge.sv
// 2-FF synchroniser for an asynchronous panel input, with a one-CLK rising-edge
// pulse taken from the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [2:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], d};
  end

  assign level = sync_pipe[1];
  assign rise  = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/i4004_run_ctrl.sv
// i4004 front-panel run controller: panel loader into program RAM, 8-phase
// machine-cycle sequencer with ROM fetch, CPU reset gating. FREE_RUN_EN selects
// an internal DIV-cycle step generator instead of MCLK stepping in run mode.
module i4004_run_ctrl
  import i4004_defs::*;
#(
  parameter int ADDR_W        = I4004_ADDR_W,
  parameter bit PANEL_REVERSE = 1'b1,
  parameter int DIV           = 1000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MCLK,
  input  logic              SWITCH,
  input  logic [15:0]       in,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_rst_n,
  output logic              step,
  output logic [2:0]        phase,
  output logic              sync,
  output logic [3:0]        rom_nib,
  output logic [ADDR_W-1:0] load_ptr
);

  if (DIV < 4) begin : g_div_chk
    $error("i4004_run_ctrl: DIV must be >= 4");
  end

  run_state_e        state, state_nxt;
  logic              mclk_rise, sw_lvl, mclk_lvl_unused, sw_rise_unused;
  logic              ev, pending, pending_nxt, w_cap, rom_cap;
  logic [15:0]       w, w_in;
  logic [7:0]        rom_byte;
  logic [2:0]        phase_nxt;
  logic [ADDR_W-1:0] load_ptr_nxt;
  logic              run_now, run_nxt;

  sync_edge u_mclk (.clk(CLK), .rst_n(RESET), .d(MCLK),   .level(mclk_lvl_unused), .rise(mclk_rise));
  sync_edge u_sw   (.clk(CLK), .rst_n(RESET), .d(SWITCH), .level(sw_lvl),          .rise(sw_rise_unused));

  assign w_in = PANEL_REVERSE ? rev16(in) : in;

`ifdef FREE_RUN_EN
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] div_cnt;

  // Held at zero outside run mode so each run session starts a full period.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                               div_cnt <= '0;
    else if (!run_now || !run_nxt)            div_cnt <= '0;
    else if (div_cnt == CW'(DIV - 1))         div_cnt <= '0;
    else                                      div_cnt <= div_cnt + CW'(1);
  end

  assign ev = run_now && (div_cnt == CW'(DIV - 1));
`else
  assign ev = mclk_rise;
`endif

  assign run_now = state inside {RUN_IDLE, RD, RD_CAP};
  assign run_nxt = state_nxt inside {RUN_IDLE, RD, RD_CAP};

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    phase_nxt    = phase;
    load_ptr_nxt = load_ptr;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    step         = 1'b0;
    w_cap        = 1'b0;
    rom_cap      = 1'b0;
    case (state)
      LOAD_IDLE: begin
        if (mclk_rise) begin
          state_nxt = WR0;
          w_cap     = 1'b1;
        end else if (sw_lvl) begin
          state_nxt = RUN_IDLE;
          phase_nxt = PH_A1;
        end
      end
      WR0: begin
        mem_we    = 1'b1;
        mem_addr  = load_ptr;
        mem_wdata = w[15:8];
        state_nxt = WR1;
      end
      WR1: begin
        mem_we       = 1'b1;
        mem_addr     = load_ptr + ADDR_W'(1);
        mem_wdata    = w[7:0];
        load_ptr_nxt = load_ptr + ADDR_W'(2);
        state_nxt    = LOAD_IDLE;
      end
      RUN_IDLE: begin
        if (sw_lvl && (ev || pending)) begin
          step        = 1'b1;
          phase_nxt   = phase + 3'd1;
          // Both a held and a fresh event: one is consumed, one stays queued.
          pending_nxt = pending & ev;
          if (phase_nxt == PH_A3) state_nxt = RD;
        end
      end
      RD: begin
        mem_re    = 1'b1;
        mem_addr  = cpu_pc;
        state_nxt = RD_CAP;
        if (ev) pending_nxt = 1'b1;
      end
      RD_CAP: begin
        rom_cap   = 1'b1;
        state_nxt = RUN_IDLE;
        if (ev) pending_nxt = 1'b1;
      end
      default: state_nxt = LOAD_IDLE;
    endcase
    // Dropping back to load mode is only honoured at a fetch boundary.
    if (!sw_lvl && (state == RUN_IDLE || state == RD_CAP)) begin
      state_nxt    = LOAD_IDLE;
      phase_nxt    = PH_A1;
      load_ptr_nxt = '0;
      pending_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= LOAD_IDLE;
      pending   <= 1'b0;
      phase     <= PH_A1;
      load_ptr  <= '0;
      w         <= '0;
      rom_byte  <= '0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      phase     <= phase_nxt;
      load_ptr  <= load_ptr_nxt;
      cpu_rst_n <= run_now && run_nxt;
      if (w_cap)   w        <= w_in;
      if (rom_cap) rom_byte <= mem_rdata;
    end
  end

  assign sync    = (phase == PH_X3);
  assign rom_nib = (phase == PH_M1) ? rom_byte[7:4] :
                   (phase == PH_M2) ? rom_byte[3:0] : 4'h0;

endmodule

// File: tb/tb_i4004_run_ctrl.sv
// Self-checking bench for i4004_run_ctrl: RAM environment, reference model of
// panel loading and phase/fetch sequencing, randomised words and fetch bytes.
module tb_i4004_run_ctrl;

  localparam int AW   = 12;
  localparam bit REV  = 1'b1;
  localparam int DIVP = 4;
  localparam int NMEM = 1 << AW;

  logic          CLK = 1'b0, RESET = 1'b1, MCLK = 1'b0, SWITCH = 1'b0;
  logic [15:0]   in_w = '0;
  logic [AW-1:0] cpu_pc = '0;
  logic          mem_we, mem_re, cpu_rst_n, step, sync;
  logic [AW-1:0] mem_addr, load_ptr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [2:0]    phase;
  logic [3:0]    rom_nib;

  int checks = 0, errors = 0;
  int we_cnt = 0, re_cnt = 0, step_cnt = 0;
  logic [AW-1:0] last_re_addr;

  logic [7:0] ram [0:NMEM-1];
  logic [7:0] exp_ram [int];
  int         exp_ptr;

  i4004_run_ctrl #(.ADDR_W(AW), .PANEL_REVERSE(REV), .DIV(DIVP)) dut (
    .CLK(CLK), .RESET(RESET), .MCLK(MCLK), .SWITCH(SWITCH), .in(in_w), .cpu_pc(cpu_pc),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_rst_n(cpu_rst_n), .step(step), .phase(phase),
    .sync(sync), .rom_nib(rom_nib), .load_ptr(load_ptr)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Bus invariants watched on every cycle out of reset.
  always @(negedge CLK) if (RESET) begin
    checks++;
    if (mem_we && mem_re) begin
      errors++; $display("FAIL strobe_overlap: we=%b re=%b, required not both high", mem_we, mem_re);
    end
    if (!mem_we && !mem_re) begin
      checks++;
      if (mem_addr !== '0) begin
        errors++; $display("FAIL addr_idle: mem_addr=%h, required 0", mem_addr);
      end
    end
    if (mem_we) we_cnt++;
    if (mem_re) begin re_cnt++; last_re_addr = mem_addr; end
    if (step) step_cnt++;
  end

  function automatic logic [15:0] panel_word(input logic [15:0] v);
    logic [15:0] r;
    if (!REV) return v;
    for (int i = 0; i < 16; i++) r[15-i] = v[i];
    return r;
  endfunction

  task automatic do_reset();
    RESET = 1'b0; MCLK = 1'b0; SWITCH = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    exp_ptr = 0;
  endtask

  task automatic pulse_mclk();
    @(negedge CLK) MCLK = 1'b1;
    repeat (3) @(negedge CLK);
    MCLK = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic load_word(input logic [15:0] v);
    logic [15:0] w;
    in_w = v;
    pulse_mclk();
    w = panel_word(v);
    exp_ram[exp_ptr] = w[15:8];
    exp_ram[(exp_ptr + 1) % NMEM] = w[7:0];
    exp_ptr = (exp_ptr + 2) % NMEM;
  endtask

  task automatic check_ram(input int a, input string nm);
    checks++;
    if (ram[a] !== exp_ram[a]) begin
      errors++; $display("FAIL %s: ram[%h]=%h, required %h", nm, a, ram[a], exp_ram[a]);
    end
  endtask

  task automatic check_ptr(input string nm);
    checks++;
    if (load_ptr !== AW'(exp_ptr)) begin
      errors++; $display("FAIL %s: load_ptr=%h, required %h", nm, load_ptr, exp_ptr);
    end
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    #3;
    checks++;
    if ({mem_we, mem_re, mem_addr, mem_wdata, cpu_rst_n, step, sync, rom_nib} !== '0) begin
      errors++; $display("FAIL reset_outputs: we=%b re=%b addr=%h wd=%h rst=%b step=%b sync=%b nib=%h, required all 0",
        mem_we, mem_re, mem_addr, mem_wdata, cpu_rst_n, step, sync, rom_nib);
    end
    checks++;
    if (phase !== 3'd0 || load_ptr !== '0) begin
      errors++; $display("FAIL reset_state: phase=%0d load_ptr=%h, required 0/0", phase, load_ptr);
    end
    do_reset();
  endtask

  task automatic test_single_load();
    int we0;
    do_reset();
    we0 = we_cnt;
    load_word(16'h0DAB);
    check_ram(0, "single_byte0");
    check_ram(1, "single_byte1");
    checks++;
    if (ram[0] !== 8'hD5 || ram[1] !== 8'hB0) begin
      errors++; $display("FAIL single_const: ram[0..1]=%h %h, required D5 B0", ram[0], ram[1]);
    end
    check_ptr("single_ptr");
    checks++;
    if (we_cnt - we0 !== 2) begin
      errors++; $display("FAIL single_we_count: %0d pulses, required 2", we_cnt - we0);
    end
  endtask

  task automatic test_multi_load();
    logic [15:0] words [4] = '{16'h0DAB, 16'h8D0B, 16'h4D0B, 16'hCD0B};
    do_reset();
    foreach (words[i]) load_word(words[i]);
    for (int a = 0; a < 8; a++) check_ram(a, "multi_fixed");
    repeat (6) load_word(16'($urandom));
    for (int a = 8; a < 20; a++) check_ram(a, "multi_random");
    check_ptr("multi_ptr");
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (NMEM / 2 - 1) load_word(16'($urandom));
    check_ptr("wrap_pre_ptr");
    load_word(16'($urandom));
    check_ram(NMEM - 2, "wrap_ffe");
    check_ram(NMEM - 1, "wrap_fff");
    check_ptr("wrap_ptr");
  endtask

  task automatic test_run();
    for (int t = 0; t < 3; t++) begin
      logic [AW-1:0] pc;
      logic [7:0]    b;
      logic [3:0]    exp_nib;
      int            re0, st0, ph;
      pc = (t == 0) ? AW'(5) : AW'($urandom_range(0, NMEM - 1));
      b  = (t == 0) ? 8'hA1 : 8'($urandom);
      do_reset();
      ram[pc] = b;
      cpu_pc = pc;
      SWITCH = 1'b1;
      repeat (6) @(negedge CLK);
      checks++;
      if (cpu_rst_n !== 1'b1 || phase !== 3'd0) begin
        errors++; $display("FAIL run_entry: cpu_rst_n=%b phase=%0d, required 1/0", cpu_rst_n, phase);
      end
      re0 = re_cnt; st0 = step_cnt;
      for (int k = 1; k <= 8; k++) begin
        pulse_mclk();
        ph = k % 8;
        exp_nib = (ph == 3) ? b[7:4] : (ph == 4) ? b[3:0] : 4'h0;
        checks++;
        if (phase !== 3'(ph) || sync !== (ph == 7) || rom_nib !== exp_nib) begin
          errors++; $display("FAIL run_phase: step %0d phase=%0d sync=%b nib=%h, required %0d/%b/%h",
            k, phase, sync, rom_nib, ph, (ph == 7), exp_nib);
        end
      end
      checks++;
      if (re_cnt - re0 !== 1 || last_re_addr !== pc || step_cnt - st0 !== 8) begin
        errors++; $display("FAIL run_fetch: re=%0d addr=%h steps=%0d, required 1/%h/8",
          re_cnt - re0, last_re_addr, step_cnt - st0, pc);
      end
    end
  endtask

  task automatic test_switch_back();
    do_reset();
    load_word(16'($urandom));
    load_word(16'($urandom));
    SWITCH = 1'b1;
    repeat (6) @(negedge CLK);
    repeat (4) pulse_mclk();
    checks++;
    if (phase !== 3'd4) begin
      errors++; $display("FAIL sw_pre_phase: phase=%0d, required 4", phase);
    end
    SWITCH = 1'b0;
    repeat (6) @(negedge CLK);
    exp_ptr = 0;
    checks++;
    if (cpu_rst_n !== 1'b0 || phase !== 3'd0) begin
      errors++; $display("FAIL sw_back: cpu_rst_n=%b phase=%0d, required 0/0", cpu_rst_n, phase);
    end
    check_ptr("sw_back_ptr");
    load_word(16'($urandom));
    check_ram(0, "sw_back_reload0");
    check_ram(1, "sw_back_reload1");
    check_ptr("sw_back_ptr2");
  endtask

  task automatic test_reset_mid_wr0();
    bit seen = 1'b0;
    do_reset();
    in_w = 16'($urandom);
    @(negedge CLK) MCLK = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (mem_we === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midwr_timeout: mem_we=%b, required 1 within 10 cycles", mem_we);
    end
    #1 RESET = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || load_ptr !== '0 || mem_addr !== '0) begin
      errors++; $display("FAIL midwr_reset: we=%b ptr=%h addr=%h, required 0/0/0", mem_we, load_ptr, mem_addr);
    end
    MCLK = 1'b0;
    do_reset();
  endtask

  task automatic test_free_run();
    int last = -1, n = 0, ph = 0, cyc = 0;
    do_reset();
    SWITCH = 1'b1;
    while (cyc < 300 && n < 12) begin
      @(negedge CLK); cyc++;
      if (step) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != DIVP) begin
            errors++; $display("FAIL free_period: %0d cycles, required %0d", cyc - last, DIVP);
          end
        end
        last = cyc; n++; ph = (ph + 1) % 8;
        @(negedge CLK); cyc++;
        checks++;
        if (phase !== 3'(ph)) begin
          errors++; $display("FAIL free_phase: phase=%0d, required %0d", phase, ph);
        end
      end
    end
    checks++;
    if (n < 12) begin
      errors++; $display("FAIL free_timeout: %0d steps, required 12", n);
    end
    SWITCH = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_multi_load();
    test_wrap();
    test_reset_mid_wr0();
`ifdef FREE_RUN_EN
    test_free_run();
`else
    test_run();
    test_switch_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
